turn_phase_fsm: RTL and testbench

//  Per-turn sequencer for the Chicken Cha-Cha-Cha game, directly upstream of next_turn.

---
 rtl/turn_phase_fsm_pkg.sv | 32 +++
 rtl/turn_phase_fsm_reveal_timer.sv | 30 +++
 rtl/turn_phase_fsm.sv | 147 ++++++++++++++
 tb/tb_turn_phase_fsm.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/turn_phase_fsm_pkg.sv
// Shared game definitions: phase encoding, card count and picture/index widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_defs;

  // Number of face-down cards on the table in the standard game.
  localparam int CARD_COUNT = 12;

  // Picture code width, shared with next_turn and the position tracker.
  localparam int PIC_W = 4;

  // Card index width; limits the table to 16 cards.
  localparam int IDX_W = 4;

  // Phase encoding as seen on Q; 3'b010 is unused and recovers to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_OVER    = 3'b001,
    ST_SHOW    = 3'b011,
    ST_PICK    = 3'b100,
    ST_COMPARE = 3'b101,
    ST_NEXT    = 3'b110,
    ST_MOVE    = 3'b111
  } phase_t;

  // A card matches when its picture equals the tile ahead of the active chicken.
  function automatic logic pics_match(input logic [PIC_W-1:0] a,
                                      input logic [PIC_W-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/turn_phase_fsm_reveal_timer.sv
// Down counter for the face-up hold: load, decrement to zero, zero flag.
// Latency: load/decrement take effect on the next edge; zero flag is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module reveal_timer #(
  parameter int RT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [RT_W-1:0] i_load_val,
  input  logic            i_dec,
  output logic            o_zero
);

  logic [RT_W-1:0] r_cnt;

  // Load has priority over decrement; the count parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/turn_phase_fsm.sv
// Per-turn sequencer: accept a card pick, compare with the target tile, then advance or reveal-and-pass.
// Latency: pick -> advance pulse 3 edges; pick -> next-turn pulse 3 + REVEAL_CYCLES edges.
// Backpressure: none; picks outside PICK (or invalid/face-up picks) are silently dropped.
module turn_phase_fsm
  import game_defs::*;
#(
  parameter int NUM_CARDS     = CARD_COUNT,
  parameter int REVEAL_CYCLES = 50,
  parameter int RT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pick_valid,
  input  logic [IDX_W-1:0]     pick_idx,
  input  logic [PIC_W-1:0]     card_pic,
  input  logic [PIC_W-1:0]     target_pic,
  input  logic                 final_step,
  output logic [2:0]           Q,
  output logic [IDX_W-1:0]     pick_q,
  output logic [NUM_CARDS-1:0] reveal_mask,
  output logic                 advance,
  output logic                 statecombo_next_turn,
  output logic                 game_over
);

  // Card count widened by one bit so an index equal to 16 can never alias.
  localparam logic [IDX_W:0]  LP_NUM    = (IDX_W+1)'(NUM_CARDS);
  // SHOW is entered with REVEAL_CYCLES-1 so it spans exactly REVEAL_CYCLES cycles.
  localparam logic [RT_W-1:0] LP_RELOAD = RT_W'(REVEAL_CYCLES - 1);

  phase_t                 r_state;
  logic [IDX_W-1:0]       r_pick_q;
  logic [NUM_CARDS-1:0]   r_mask;
  logic                   r_advance;
  logic                   r_turn;
  logic                   r_game_over;

  logic [NUM_CARDS-1:0]   w_set;
  logic                   w_idx_ok;
  logic                   w_card_down;
  logic                   w_pick_ok;
  logic                   w_all_up;
  logic                   w_pic_eq;
  logic                   w_tmr_load;
  logic                   w_tmr_dec;
  logic                   w_tmr_zero;

  // One-hot of the requested card; shifts out to zero for indices past the table,
  // which are rejected by w_idx_ok anyway.
  assign w_set       = NUM_CARDS'(1) << pick_idx;
  assign w_idx_ok    = ({1'b0, pick_idx} < LP_NUM);
  assign w_card_down = ~|(r_mask & w_set);
  assign w_pick_ok   = pick_valid & w_idx_ok & w_card_down;
  assign w_all_up    = &r_mask;
  assign w_pic_eq    = pics_match(card_pic, target_pic);

  // The timer is armed on a mismatch and only counts while the card is on show.
  assign w_tmr_load  = (r_state == ST_COMPARE) && !w_pic_eq;
  assign w_tmr_dec   = (r_state == ST_SHOW);

  reveal_timer #(
    .RT_W (RT_W)
  ) u_reveal_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (LP_RELOAD),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // Phase sequencer with the mask, latched pick and the one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pick_q    <= '0;
      r_mask      <= '0;
      r_advance   <= 1'b0;
      r_turn      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      // Pulses default low so each is high for only the cycle after MOVE/NEXT.
      r_advance <= 1'b0;
      r_turn    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_PICK;
          end
        end
        ST_PICK: begin
          // A fully revealed table leaves nothing to pick: pass the turn.
          if (w_all_up) begin
            r_state <= ST_NEXT;
          end else if (w_pick_ok) begin
            r_pick_q <= pick_idx;
            r_mask   <= r_mask | w_set;
            r_state  <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          // card_pic is looked up from pick_q, which was registered last edge.
          r_state <= w_pic_eq ? ST_MOVE : ST_SHOW;
        end
        ST_MOVE: begin
          r_advance <= 1'b1;
          if (final_step) begin
            r_state     <= ST_OVER;
            r_game_over <= 1'b1;
          end else begin
            r_state <= ST_PICK;
          end
        end
        ST_SHOW: begin
          if (w_tmr_zero) begin
            r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          r_turn  <= 1'b1;
          r_mask  <= '0;
          r_state <= ST_PICK;
        end
        ST_OVER: begin
          // Restart keeps the chickens' positions but turns all cards face-down.
          if (start) begin
            r_state     <= ST_PICK;
            r_mask      <= '0;
            r_game_over <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Q                    = r_state;
  assign pick_q               = r_pick_q;
  assign reveal_mask          = r_mask;
  assign advance              = r_advance;
  assign statecombo_next_turn = r_turn;
  assign game_over            = r_game_over;

endmodule

// File: tb/tb_turn_phase_fsm.sv
// Directed bench for turn_phase_fsm: a 12-card/4-cycle instance and a 2-card instance.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_turn_phase_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        pick_valid = 1'b0;
  logic [3:0]  pick_idx = '0;
  logic [3:0]  card_pic = '0;
  logic [3:0]  target_pic = '0;
  logic        final_step = 1'b0;

  logic [2:0]  q_a, q_b;
  logic [3:0]  pq_a, pq_b;
  logic [11:0] mask_a;
  logic [1:0]  mask_b;
  logic        adv_a, adv_b, turn_a, turn_b, go_a, go_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  turn_phase_fsm #(.NUM_CARDS(12), .REVEAL_CYCLES(4), .RT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .pick_valid(pick_valid),
    .pick_idx(pick_idx), .card_pic(card_pic), .target_pic(target_pic),
    .final_step(final_step), .Q(q_a), .pick_q(pq_a), .reveal_mask(mask_a),
    .advance(adv_a), .statecombo_next_turn(turn_a), .game_over(go_a)
  );

  turn_phase_fsm #(.NUM_CARDS(2), .REVEAL_CYCLES(4), .RT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .pick_valid(pick_valid),
    .pick_idx(pick_idx), .card_pic(card_pic), .target_pic(target_pic),
    .final_step(final_step), .Q(q_b), .pick_q(pq_b), .reveal_mask(mask_b),
    .advance(adv_b), .statecombo_next_turn(turn_b), .game_over(go_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #2;
    n_checks++; if (q_a !== 3'b000) begin n_errors++; $display("FAIL rst_q got %b exp 000", q_a); end
    n_checks++; if (mask_a !== 12'h000) begin n_errors++; $display("FAIL rst_mask got %h exp 000", mask_a); end
    n_checks++; if ({adv_a, turn_a, go_a} !== 3'b000) begin n_errors++; $display("FAIL rst_flags got %b exp 000", {adv_a, turn_a, go_a}); end
    n_checks++; if (pq_a !== 4'd0) begin n_errors++; $display("FAIL rst_pick_q got %0d exp 0", pq_a); end
    tick;
    rst_n = 1'b1;
    tick;
    n_checks++; if (q_a !== 3'b000) begin n_errors++; $display("FAIL idle_hold got %b exp 000", q_a); end
    start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++; if (q_a !== 3'b100) begin n_errors++; $display("FAIL start_pick got %b exp 100", q_a); end
  endtask

  task automatic test_match;
    pick_valid = 1'b1; pick_idx = 4'd3; card_pic = 4'd5; target_pic = 4'd5; final_step = 1'b0;
    tick;
    pick_valid = 1'b0;
    n_checks++; if (q_a !== 3'b101) begin n_errors++; $display("FAIL m_compare got %b exp 101", q_a); end
    n_checks++; if (mask_a !== 12'h008) begin n_errors++; $display("FAIL m_mask got %h exp 008", mask_a); end
    n_checks++; if (pq_a !== 4'd3) begin n_errors++; $display("FAIL m_pick_q got %0d exp 3", pq_a); end
    tick;
    n_checks++; if (q_a !== 3'b111 || adv_a !== 1'b0) begin n_errors++; $display("FAIL m_move got q=%b adv=%b exp q=111 adv=0", q_a, adv_a); end
    tick;
    n_checks++; if (q_a !== 3'b100 || adv_a !== 1'b1) begin n_errors++; $display("FAIL m_adv got q=%b adv=%b exp q=100 adv=1", q_a, adv_a); end
    n_checks++; if (turn_a !== 1'b0) begin n_errors++; $display("FAIL m_no_turn got %b exp 0", turn_a); end
    tick;
    n_checks++; if (adv_a !== 1'b0 || q_a !== 3'b100 || mask_a !== 12'h008) begin n_errors++; $display("FAIL m_after got adv=%b q=%b mask=%h exp 0/100/008", adv_a, q_a, mask_a); end
  endtask

  task automatic test_mismatch;
    pick_valid = 1'b1; pick_idx = 4'd7; card_pic = 4'd2; target_pic = 4'd9;
    tick;
    pick_valid = 1'b0;
    n_checks++; if (q_a !== 3'b101 || mask_a !== 12'h088) begin n_errors++; $display("FAIL mm_compare got q=%b mask=%h exp 101/088", q_a, mask_a); end
    for (int i = 0; i < 4; i++) begin
      // A pick during SHOW must be dropped.
      pick_valid = (i == 1); pick_idx = 4'd0;
      tick;
      n_checks++; if (q_a !== 3'b011 || turn_a !== 1'b0 || mask_a !== 12'h088) begin n_errors++; $display("FAIL mm_show%0d got q=%b turn=%b mask=%h exp 011/0/088", i, q_a, turn_a, mask_a); end
    end
    pick_valid = 1'b0;
    tick;
    n_checks++; if (q_a !== 3'b110 || turn_a !== 1'b0) begin n_errors++; $display("FAIL mm_next got q=%b turn=%b exp 110/0", q_a, turn_a); end
    tick;
    n_checks++; if (q_a !== 3'b100 || turn_a !== 1'b1 || mask_a !== 12'h000) begin n_errors++; $display("FAIL mm_turn got q=%b turn=%b mask=%h exp 100/1/000", q_a, turn_a, mask_a); end
    n_checks++; if (adv_a !== 1'b0) begin n_errors++; $display("FAIL mm_no_adv got %b exp 0", adv_a); end
    tick;
    n_checks++; if (turn_a !== 1'b0) begin n_errors++; $display("FAIL mm_turn_end got %b exp 0", turn_a); end
  endtask

  task automatic test_ignored_picks;
    pick_valid = 1'b1; pick_idx = 4'd3; card_pic = 4'd5; target_pic = 4'd5;
    tick; pick_valid = 1'b0; tick; tick; tick;
    n_checks++; if (q_a !== 3'b100 || mask_a !== 12'h008) begin n_errors++; $display("FAIL ig_setup got q=%b mask=%h exp 100/008", q_a, mask_a); end
    pick_valid = 1'b1; pick_idx = 4'd3;
    tick;
    n_checks++; if (q_a !== 3'b100 || mask_a !== 12'h008) begin n_errors++; $display("FAIL ig_faceup got q=%b mask=%h exp 100/008", q_a, mask_a); end
    pick_idx = 4'd13;
    tick;
    n_checks++; if (q_a !== 3'b100 || mask_a !== 12'h008 || pq_a !== 4'd3) begin n_errors++; $display("FAIL ig_idx13 got q=%b mask=%h pq=%0d exp 100/008/3", q_a, mask_a, pq_a); end
    pick_idx = 4'd12;
    tick;
    pick_valid = 1'b0;
    n_checks++; if (q_a !== 3'b100 || mask_a !== 12'h008) begin n_errors++; $display("FAIL ig_idx12 got q=%b mask=%h exp 100/008", q_a, mask_a); end
  endtask

  task automatic test_game_over;
    pick_valid = 1'b1; pick_idx = 4'd5; card_pic = 4'd6; target_pic = 4'd6; final_step = 1'b1;
    tick;
    pick_valid = 1'b0;
    n_checks++; if (q_a !== 3'b101 || mask_a !== 12'h028) begin n_errors++; $display("FAIL go_compare got q=%b mask=%h exp 101/028", q_a, mask_a); end
    tick;
    n_checks++; if (q_a !== 3'b111 || go_a !== 1'b0) begin n_errors++; $display("FAIL go_move got q=%b go=%b exp 111/0", q_a, go_a); end
    tick;
    final_step = 1'b0;
    n_checks++; if (q_a !== 3'b001 || adv_a !== 1'b1 || go_a !== 1'b1) begin n_errors++; $display("FAIL go_over got q=%b adv=%b go=%b exp 001/1/1", q_a, adv_a, go_a); end
    pick_valid = 1'b1; pick_idx = 4'd0;
    tick;
    pick_valid = 1'b0;
    n_checks++; if (q_a !== 3'b001 || adv_a !== 1'b0 || go_a !== 1'b1 || mask_a !== 12'h028) begin n_errors++; $display("FAIL go_hold got q=%b adv=%b go=%b mask=%h exp 001/0/1/028", q_a, adv_a, go_a, mask_a); end
    start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++; if (q_a !== 3'b100 || go_a !== 1'b0 || mask_a !== 12'h000) begin n_errors++; $display("FAIL go_restart got q=%b go=%b mask=%h exp 100/0/000", q_a, go_a, mask_a); end
  endtask

  task automatic test_full_table;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++; if (q_b !== 3'b100) begin n_errors++; $display("FAIL ft_start got %b exp 100", q_b); end
    card_pic = 4'd1; target_pic = 4'd1;
    for (int c = 0; c < 2; c++) begin
      pick_valid = 1'b1; pick_idx = 4'(c);
      tick;
      pick_valid = 1'b0;
      tick; tick;
      n_checks++; if (q_b !== 3'b100 || adv_b !== 1'b1) begin n_errors++; $display("FAIL ft_adv%0d got q=%b adv=%b exp 100/1", c, q_b, adv_b); end
    end
    n_checks++; if (mask_b !== 2'b11) begin n_errors++; $display("FAIL ft_mask got %b exp 11", mask_b); end
    tick;
    n_checks++; if (q_b !== 3'b110 || adv_b !== 1'b0) begin n_errors++; $display("FAIL ft_next got q=%b adv=%b exp 110/0", q_b, adv_b); end
    tick;
    n_checks++; if (q_b !== 3'b100 || turn_b !== 1'b1 || mask_b !== 2'b00) begin n_errors++; $display("FAIL ft_turn got q=%b turn=%b mask=%b exp 100/1/00", q_b, turn_b, mask_b); end
  endtask

  task automatic test_reset_mid_show;
    pick_valid = 1'b1; pick_idx = 4'd4; card_pic = 4'd2; target_pic = 4'd9;
    tick;
    pick_valid = 1'b0;
    tick; tick;
    n_checks++; if (q_a !== 3'b011) begin n_errors++; $display("FAIL rs_in_show got %b exp 011", q_a); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (q_a !== 3'b000 || mask_a !== 12'h000 || turn_a !== 1'b0) begin n_errors++; $display("FAIL rs_async got q=%b mask=%h turn=%b exp 000/000/0", q_a, mask_a, turn_a); end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      n_checks++; if (turn_a !== 1'b0 || q_a !== 3'b000) begin n_errors++; $display("FAIL rs_quiet%0d got turn=%b q=%b exp 0/000", i, turn_a, q_a); end
    end
  endtask

  initial begin
    test_reset;
    test_match;
    test_mismatch;
    test_ignored_picks;
    test_game_over;
    test_full_table;
    test_reset_mid_show;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
